// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the front-side-bus hop blocks.
// Provides the channel id width helper and the default per-channel slice width.
package bsg_fsb_pkg;

    localparam int fsb_slice_width_lp = 16;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fsb_rr_arb.sv
// Round-robin arbiter with grant hold: a stalled grant is replayed until it transfers.
// Search starts at rr_ptr_i and wraps by compare-and-subtract, so any fan-in works.
module bsg_fsb_rr_arb
    import bsg_fsb_pkg::*;
#(
    parameter int fan_in_p = 5
) (
    input  logic [fan_in_p-1:0]             req_i,
    input  logic [id_width(fan_in_p)-1:0]   rr_ptr_i,
    input  logic                            hold_i,
    input  logic [id_width(fan_in_p)-1:0]   hold_id_i,
    output logic [fan_in_p-1:0]             grant_oh_o,
    output logic [id_width(fan_in_p)-1:0]   grant_id_o,
    output logic                            v_o
);

    localparam int id_w_lp = id_width(fan_in_p);

    logic               w_found;
    logic [id_w_lp-1:0] w_first;
    logic [id_w_lp-1:0] w_cand;
    int                 w_sum;

    always_comb begin
        w_found = 1'b0;
        w_first = '0;
        w_cand  = '0;
        w_sum   = 0;
        for (int i = 0; i < fan_in_p; i++) begin
            w_sum = int'(rr_ptr_i) + i;
            if (w_sum >= fan_in_p) w_sum = w_sum - fan_in_p;
            w_cand = id_w_lp'(w_sum);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                w_first = w_cand;
            end
        end
    end

    assign grant_id_o = hold_i ? hold_id_i : w_first;
    assign v_o        = hold_i | w_found;

    always_comb begin
        grant_oh_o = '0;
        for (int k = 0; k < fan_in_p; k++) begin
            grant_oh_o[k] = v_o && (grant_id_o == id_w_lp'(k));
        end
    end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO, ready/valid on the input side and valid/yumi on the output side.
// ready_o reflects the registered full flag, so it never rises in the cycle of a dequeue.
module bsg_two_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_head;
    logic               r_tail;
    logic               r_empty;
    logic               r_full;
    logic               w_enq;
    logic               w_deq;

    assign w_enq   = v_i & ~r_full;
    assign w_deq   = yumi_i & ~r_empty;
    assign ready_o = ~r_full;
    assign v_o     = ~r_empty;
    assign data_o  = r_mem[r_head];

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_tail] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_enq) r_tail <= ~r_tail;
            if (w_deq) r_head <= ~r_head;
            // Occupancy only changes when exactly one side fires.
            if (w_enq && !w_deq) begin
                r_empty <= 1'b0;
                r_full  <= ~r_empty;
            end else if (w_deq && !w_enq) begin
                r_full  <= 1'b0;
                r_empty <= ~r_full;
            end
        end
    end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// FSB hop return path: per-channel two-entry FIFOs merged round-robin onto one link.
// The pointer and hold registers live here; the arbiter itself is purely combinational.
module bsg_front_side_bus_hop_out
    import bsg_fsb_pkg::*;
#(
    parameter int fan_in_p = 5,
    parameter int width_p  = fsb_slice_width_lp
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [fan_in_p-1:0]             v_i,
    input  logic [fan_in_p*width_p-1:0]     data_i,
    output logic [fan_in_p-1:0]             ready_o,
    output logic                            v_o,
    output logic [width_p-1:0]              data_o,
    input  logic                            ready_i,
    output logic [id_width(fan_in_p)-1:0]   grant_id_o
);

    localparam int id_w_lp = id_width(fan_in_p);

    logic [fan_in_p-1:0] w_req;
    logic [fan_in_p-1:0] w_yumi;
    logic [fan_in_p-1:0] w_grant_oh;
    logic [width_p-1:0]  w_head [fan_in_p];
    logic [id_w_lp-1:0]  w_grant_id;
    logic                w_v;
    logic                w_xfer;
    logic [id_w_lp-1:0]  r_rr_ptr;
    logic                r_hold;
    logic [id_w_lp-1:0]  r_hold_id;

    for (genvar k = 0; k < fan_in_p; k++) begin : g_ch
        bsg_two_fifo #(.width_p(width_p)) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (v_i[k]),
            .data_i  (data_i[k*width_p +: width_p]),
            .ready_o (ready_o[k]),
            .v_o     (w_req[k]),
            .data_o  (w_head[k]),
            .yumi_i  (w_yumi[k])
        );
    end

    bsg_fsb_rr_arb #(.fan_in_p(fan_in_p)) u_arb (
        .req_i      (w_req),
        .rr_ptr_i   (r_rr_ptr),
        .hold_i     (r_hold),
        .hold_id_i  (r_hold_id),
        .grant_oh_o (w_grant_oh),
        .grant_id_o (w_grant_id),
        .v_o        (w_v)
    );

    assign w_xfer     = w_v & ready_i;
    assign w_yumi     = w_xfer ? w_grant_oh : '0;
    assign v_o        = w_v;
    assign data_o     = w_head[w_grant_id];
    assign grant_id_o = w_grant_id;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_ptr  <= '0;
            r_hold    <= 1'b0;
            r_hold_id <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_grant_id == id_w_lp'(fan_in_p - 1)) ? '0 : w_grant_id + id_w_lp'(1);
            r_hold   <= 1'b0;
        end else if (w_v) begin
            // Stalled: freeze the winner so the link word cannot change before acceptance.
            r_hold    <= 1'b1;
            r_hold_id <= w_grant_id;
        end
    end

endmodule
